// File: rtl/vote_capture.sv
// vote_capture: ballot-entry stage ahead of the per-candidate vote counters.
// Synchronises and debounces four candidate buttons, allows one vote per
// armed ballot, rejects multi-button presses and emits single-cycle pulses.
module vote_capture #(
  parameter int DB_CYCLES = 16,
  parameter int DB_W      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] button,
  input  logic       ballot_arm,
  input  logic       mode,
  output logic [3:0] valid_vote,
  output logic       ready,
  output logic       invalid,
  output logic       voted
);

  // Debounce length must fit the counter and be long enough to mean anything.
  generate
    if ((DB_CYCLES < 2) || (DB_CYCLES > ((2 ** DB_W) - 1))) begin : g_bad_db_cycles
      $error("vote_capture: DB_CYCLES must be in 2..2**DB_W-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_ARMED    = 2'd1,
    ST_DEBOUNCE = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Terminal count: the counter is compared before it increments, so the
  // last stable sample is seen when it holds DB_CYCLES-1.
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] CNT_ZERO = DB_W'(0);
  localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

  // True when exactly one candidate bit is set.
  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  // Ready LED is lit while a ballot is armed and no press has been accepted.
  function automatic logic ready_for(input state_t s);
    return (s == ST_ARMED) || (s == ST_DEBOUNCE);
  endfunction

  logic [3:0]      r_sync1;
  logic [3:0]      r_sbtn;
  state_t          r_state;
  logic [3:0]      r_sample;
  logic [DB_W-1:0] r_cnt;
  logic            r_cast;
  logic [3:0]      r_valid_vote;
  logic            r_ready;
  logic            r_invalid;
  logic            r_voted;

  state_t          w_state_nxt;
  logic [3:0]      w_sample_nxt;
  logic [DB_W-1:0] w_cnt_nxt;
  logic            w_cast_nxt;
  logic [3:0]      w_valid_nxt;
  logic            w_invalid_nxt;
  logic            w_ready_nxt;
  logic            w_voted_nxt;

  // Two-flop synchroniser on the raw asynchronous buttons.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 4'b0000;
      r_sbtn  <= 4'b0000;
    end else begin
      r_sync1 <= button;
      r_sbtn  <= r_sync1;
    end
  end

  // Next-state and next-output logic; mode overrides every state.
  always_comb begin
    w_state_nxt   = r_state;
    w_sample_nxt  = r_sample;
    w_cnt_nxt     = r_cnt;
    w_cast_nxt    = r_cast;
    w_valid_nxt   = 4'b0000;
    w_invalid_nxt = 1'b0;

    if (mode) begin
      // Display mode: drop any in-progress press and lock the ballot.
      w_state_nxt  = ST_LOCKED;
      w_sample_nxt = 4'b0000;
      w_cnt_nxt    = CNT_ZERO;
      w_cast_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_LOCKED: begin
          if (ballot_arm) begin
            w_state_nxt = ST_ARMED;
            w_cnt_nxt   = CNT_ZERO;
          end else begin
            w_state_nxt = ST_LOCKED;
          end
        end

        ST_ARMED: begin
          if (r_sbtn != 4'b0000) begin
            w_state_nxt  = ST_DEBOUNCE;
            w_sample_nxt = r_sbtn;
            w_cnt_nxt    = CNT_ONE;
          end else begin
            w_state_nxt = ST_ARMED;
          end
        end

        ST_DEBOUNCE: begin
          if (r_sbtn == r_sample) begin
            if (r_cnt >= CNT_LAST) begin
              // Press accepted: a single candidate votes, anything else is rejected.
              if (is_one_hot(r_sample)) begin
                w_valid_nxt = r_sample;
                w_cast_nxt  = 1'b1;
              end else begin
                w_invalid_nxt = 1'b1;
                w_cast_nxt    = 1'b0;
              end
              w_state_nxt = ST_RELEASE;
              w_cnt_nxt   = CNT_ZERO;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end else if (r_sbtn == 4'b0000) begin
            // Contact bounced open before the press was stable.
            w_state_nxt = ST_ARMED;
            w_cnt_nxt   = CNT_ZERO;
          end else begin
            // Different button pattern: restart debounce on the new pattern.
            w_sample_nxt = r_sbtn;
            w_cnt_nxt    = CNT_ONE;
          end
        end

        ST_RELEASE: begin
          if (r_sbtn == 4'b0000) begin
            if (r_cnt >= CNT_LAST) begin
              // Buttons cleanly released: a cast vote closes the ballot,
              // a rejected press lets the voter try again.
              w_state_nxt = r_cast ? ST_LOCKED : ST_ARMED;
              w_cnt_nxt   = CNT_ZERO;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end else begin
            w_cnt_nxt = CNT_ZERO;
          end
        end

        default: begin
          w_state_nxt  = ST_LOCKED;
          w_sample_nxt = 4'b0000;
          w_cnt_nxt    = CNT_ZERO;
          w_cast_nxt   = 1'b0;
        end
      endcase
    end

    w_ready_nxt = ready_for(w_state_nxt);
    w_voted_nxt = |w_valid_nxt;
  end

  // FSM state, debounce bookkeeping and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_LOCKED;
      r_sample     <= 4'b0000;
      r_cnt        <= CNT_ZERO;
      r_cast       <= 1'b0;
      r_valid_vote <= 4'b0000;
      r_ready      <= 1'b0;
      r_invalid    <= 1'b0;
      r_voted      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sample     <= w_sample_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cast       <= w_cast_nxt;
      r_valid_vote <= w_valid_nxt;
      r_ready      <= w_ready_nxt;
      r_invalid    <= w_invalid_nxt;
      r_voted      <= w_voted_nxt;
    end
  end

  assign valid_vote = r_valid_vote;
  assign ready      = r_ready;
  assign invalid    = r_invalid;
  assign voted      = r_voted;

endmodule

// File: tb/tb_vote_capture.sv
// Self-checking bench for vote_capture with DB_CYCLES=4: directed scenarios
// with literal expectations plus randomized traffic against a run-length model.
module tb_vote_capture;
  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] button;
  logic       ballot_arm;
  logic       mode;
  logic [3:0] valid_vote;
  logic       ready;
  logic       invalid;
  logic       voted;

  vote_capture #(.DB_CYCLES(DB), .DB_W(8)) dut (
    .clock(clock), .reset(reset), .button(button), .ballot_arm(ballot_arm),
    .mode(mode), .valid_vote(valid_vote), .ready(ready), .invalid(invalid),
    .voted(voted)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 = ballot closed, 1 = waiting for a press, 2 = waiting for release.
  logic [3:0] m_d1, m_d2, m_last;
  int         m_phase, m_run, m_zrun;
  bit         m_cast;
  logic [3:0] e_valid;
  logic       e_ready, e_inv, e_voted;

  // Directed-scenario observation counters.
  int         n_valid, n_inv, n_voted, step_no, first_valid_step;
  logic [3:0] last_valid;

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic [3:0] s;
    e_valid = 4'b0000;
    e_inv   = 1'b0;
    if (reset) begin
      m_d1 = 4'b0000; m_d2 = 4'b0000; m_last = 4'b0000;
      m_phase = 0; m_run = 0; m_zrun = 0; m_cast = 1'b0;
    end else begin
      s    = m_d2;
      m_d2 = m_d1;
      m_d1 = button;
      if (mode) begin
        m_phase = 0; m_run = 0; m_zrun = 0;
      end else if (m_phase == 0) begin
        if (ballot_arm) begin
          m_phase = 1; m_run = 0;
        end
      end else if (m_phase == 1) begin
        if (s == 4'b0000) m_run = 0;
        else begin
          if (m_run != 0 && s == m_last) m_run++;
          else m_run = 1;
          m_last = s;
        end
        if (m_run == DB) begin
          if ($countones(s) == 1) begin e_valid = s; m_cast = 1'b1; end
          else begin e_inv = 1'b1; m_cast = 1'b0; end
          m_phase = 2; m_zrun = 0;
        end
      end else begin
        if (s == 4'b0000) m_zrun++;
        else m_zrun = 0;
        if (m_zrun == DB) begin
          m_phase = m_cast ? 0 : 1;
          m_run = 0;
        end
      end
    end
    e_ready = (m_phase == 1);
    e_voted = (e_valid != 4'b0000);
  endtask

  // One clock: update model at the edge, then compare away from the edge.
  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    chk4("valid_vote", valid_vote, e_valid);
    chk1("ready", ready, e_ready);
    chk1("invalid", invalid, e_inv);
    chk1("voted", voted, e_voted);
    step_no++;
    if (valid_vote != 4'b0000) begin
      n_valid++;
      last_valid = valid_vote;
      if (first_valid_step < 0) first_valid_step = step_no;
    end
    if (invalid) n_inv++;
    if (voted) n_voted++;
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    button = b;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic arm();
    ballot_arm = 1'b1;
    step();
    ballot_arm = 1'b0;
  endtask

  task automatic clear_obs();
    n_valid = 0; n_inv = 0; n_voted = 0; step_no = 0;
    first_valid_step = -1; last_valid = 4'b0000;
  endtask

  function automatic logic [3:0] rand_btn();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 4'b0000;
    else if (r < 8) return 4'(1 << $urandom_range(0, 3));
    else return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    reset = 1'b1; button = 4'b0000; ballot_arm = 1'b0; mode = 1'b0;
    clear_obs();
    for (int i = 0; i < 3; i++) step();
    chk4("reset_valid", valid_vote, 4'b0000);
    chk1("reset_ready", ready, 1'b0);
    chk1("reset_invalid", invalid, 1'b0);
    chk1("reset_voted", voted, 1'b0);
    reset = 1'b0;
    hold(4'b0000, 3);

    // Clean vote with latency pin.
    arm();
    chk1("armed_ready", ready, 1'b1);
    clear_obs();
    hold(4'b0010, 20);
    chkn("clean_latency_step", first_valid_step, 6);
    chk4("clean_value", last_valid, 4'b0010);
    chk1("clean_ready_after", ready, 1'b0);
    hold(4'b0000, 8);
    hold(4'b0010, 12);
    hold(4'b0000, 8);
    chkn("clean_pulses", n_valid, 1);
    chkn("clean_voted_pulses", n_voted, 1);

    // Bounce rejection.
    arm();
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      hold(4'b0100, 2);
      hold(4'b0000, 2);
    end
    chkn("bounce_no_pulse", n_valid, 0);
    hold(4'b0100, 12);
    hold(4'b0000, 8);
    chkn("bounce_pulses", n_valid, 1);
    chk4("bounce_value", last_valid, 4'b0100);

    // Multi-button press, then retry.
    arm();
    clear_obs();
    hold(4'b1001, 10);
    hold(4'b0000, 8);
    chkn("multi_invalid", n_inv, 1);
    chkn("multi_no_valid", n_valid, 0);
    chk1("multi_rearmed", ready, 1'b1);
    hold(4'b1000, 10);
    hold(4'b0000, 8);
    chkn("retry_pulses", n_valid, 1);
    chk4("retry_value", last_valid, 4'b1000);

    // Held button without arm, then arm while held.
    clear_obs();
    hold(4'b0001, 10);
    chkn("noarm_no_pulse", n_valid, 0);
    arm();
    hold(4'b0001, 30);
    chkn("held_arm_pulses", n_valid, 1);
    hold(4'b0000, 8);

    // Mode abort at cnt=2.
    arm();
    clear_obs();
    hold(4'b0001, 4);
    mode = 1'b1;
    step();
    chk1("mode_ready", ready, 1'b0);
    mode = 1'b0;
    hold(4'b0001, 6);
    hold(4'b0000, 8);
    chkn("mode_no_pulse", n_valid, 0);

    // Reset abort mid-debounce.
    arm();
    clear_obs();
    hold(4'b0001, 4);
    reset = 1'b1;
    step();
    chk4("rst_valid", valid_vote, 4'b0000);
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_invalid", invalid, 1'b0);
    chk1("rst_voted", voted, 1'b0);
    reset = 1'b0;
    hold(4'b0001, 10);
    hold(4'b0000, 8);
    chkn("rst_no_pulse", n_valid, 0);

    // Arm ignored in debounce and release.
    arm();
    clear_obs();
    hold(4'b0010, 4);
    arm();
    hold(4'b0010, 6);
    arm();
    hold(4'b0010, 2);
    hold(4'b0000, 8);
    chkn("arm_ignored_pulses", n_valid, 1);
    chkn("arm_ignored_voted", n_voted, 1);
    chk1("arm_ignored_locked", ready, 1'b0);

    // Randomized traffic against the model.
    button = 4'b0000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 4) == 0) button = rand_btn();
      ballot_arm = ($urandom_range(0, 19) == 0);
      mode       = ($urandom_range(0, 79) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; mode = 1'b0; ballot_arm = 1'b0; button = 4'b0000;
    hold(4'b0000, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
